// File: rtl/shift_sequencer.sv
// Multi-cycle shift controller: steps an external single-bit shifter
// once per clock for 0..2^AMT_W-1 positions, with a start/done handshake.
module shift_sequencer #(
    parameter int WIDTH = 8,
    parameter int AMT_W = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [WIDTH-1:0] A,
    input  logic             LA,
    input  logic             LR,
    input  logic [AMT_W-1:0] AMT,
    output logic [WIDTH-1:0] SH_A,
    output logic             SH_LA,
    output logic             SH_LR,
    input  logic [WIDTH-1:0] SH_Y,
    input  logic             SH_C,
    output logic [WIDTH-1:0] Y,
    output logic             C,
    output logic             busy,
    output logic             done
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] work_q, work_d;
    logic [AMT_W-1:0] cnt_q, cnt_d;
    logic             c_q, c_d;
    logic             la_q, la_d;
    logic             lr_q, lr_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;

    always_comb begin
        state_d = state_q;
        work_d  = work_q;
        cnt_d   = cnt_q;
        c_d     = c_q;
        la_d    = la_q;
        lr_d    = lr_q;
        unique case (state_q)
            IDLE: begin
                if (start) begin
                    work_d  = A;
                    cnt_d   = AMT;
                    c_d     = 1'b0;
                    la_d    = LA;
                    lr_d    = LR;
                    state_d = (AMT == '0) ? DONE : SHIFT;
                end
            end
            SHIFT: begin
                // count is always >= 1 here, so it never wraps
                work_d = SH_Y;
                c_d    = SH_C;
                cnt_d  = cnt_q - 1'b1;
                if (cnt_q == AMT_W'(1)) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
        busy_d = (state_d != IDLE);
        done_d = (state_d == DONE);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            work_q  <= '0;
            cnt_q   <= '0;
            c_q     <= 1'b0;
            la_q    <= 1'b0;
            lr_q    <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            work_q  <= work_d;
            cnt_q   <= cnt_d;
            c_q     <= c_d;
            la_q    <= la_d;
            lr_q    <= lr_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    assign SH_A  = work_q;
    assign SH_LA = la_q;
    assign SH_LR = lr_q;
    assign Y     = work_q;
    assign C     = c_q;
    assign busy  = busy_q;
    assign done  = done_q;

endmodule

// File: doc/shift_sequencer.md
Name: shift_sequencer

Overview:
- Multi-cycle shift controller that drives the existing single-bit combinational shifter (A/LA/LR in, Y/C out) once per clock to perform shifts of 0..15 positions.
- Sits between the ALU/control path and the shifter. It feeds the shifter's operand and mode inputs and consumes its Y/C every cycle.
- Returns the final result and last carry-out with a start/done handshake.

Parameters:
- WIDTH, 8, data width; must match the shifter.
- AMT_W, 4, shift-amount width; maximum shift is 2^AMT_W-1.

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  asynchronous, active-high reset.
- start  input  1  request; sampled only in IDLE.
- A  input  WIDTH  operand, latched on an accepted start.
- LA  input  1  0 = logical, 1 = arithmetic; latched on start.
- LR  input  1  0 = left, 1 = right; latched on start. When LR=0, LA is ignored (left is always logical).
- AMT  input  AMT_W  shift count; latched on start.
- SH_A  output  WIDTH  to shifter A; equals the working register.
- SH_LA  output  1  to shifter LA; the latched LA.
- SH_LR  output  1  to shifter LR; the latched LR.
- SH_Y  input  WIDTH  from shifter Y.
- SH_C  input  1  from shifter C.
- Y  output  WIDTH  result; equals the working register.
- C  output  1  last bit shifted out.
- busy  output  1  high whenever state != IDLE.
- done  output  1  one-cycle registered pulse; Y/C valid.

Behaviour:
- Clock and reset: one clock (clk). reset is asynchronous and active-high.
- Reset values: state=IDLE; working register, Y, C, count, latched LA/LR all 0; busy=0; done=0.
- FSM states: IDLE, SHIFT, DONE.
- IDLE:
  - start=1 at an edge loads work<=A, count<=AMT, C<=0, and latches LA/LR.
  - Next state is DONE if AMT==0, otherwise SHIFT.
  - start=0 keeps the state in IDLE and holds Y/C.
- SHIFT: each edge does work<=SH_Y, C<=SH_C, count<=count-1. When count==1 at that edge, next state is DONE.
- DONE:
  - done=1 for exactly this one cycle.
  - Next edge returns to IDLE unconditionally.
  - A start asserted during DONE is ignored.
- Latency:
  - With the start edge as edge 0, done is high in the cycle following edge N (N = AMT).
  - AMT=0 gives done right after edge 0 with Y=A and C=0.
  - Total occupancy is N+1 cycles before IDLE; a back-to-back start is accepted at the edge ending DONE+1.
- start while busy (SHIFT or DONE): ignored. Latched operands and count are unaffected.
- Result hold: Y/C stay stable from done until the next accepted start. Between start and done, Y shows intermediate values and is not valid.
- Shift semantics come entirely from the external shifter, applied N times:
  - Logical shifts of N>=WIDTH give Y=0. C is the last bit out, which is 0 once all original bits are gone.
  - Arithmetic right shifts of N>=WIDTH give all sign bits, with C = the sign bit.
- The count never wraps. It is only decremented in SHIFT, where it is >=1.
- Reset asserted mid-operation immediately forces the reset values. The in-flight result is discarded and no done is produced.
- SH_LA/SH_LR come from the latched registers, not the live inputs. Changing LA/LR/A/AMT during busy has no effect.

Test Plan:
- LR=0, A=0x81, AMT=1, start pulse -> SH_A=0x81 in SHIFT. done after edge 1 with Y=0x02, C=1. busy high for 2 cycles.
- LR=1, LA=1, A=0x90, AMT=3 -> done after edge 3 with Y=0xF2, C=0. Intermediate SH_A values are 0x90, 0xC8, 0xE4.
- LR=1, LA=0, A=0x0F, AMT=4 -> Y=0x00, C=1, done after edge 4. LR=0, A=0xFF, AMT=10 -> Y=0x00, C=0, done after edge 10.
- AMT=0, A=0x5A -> done after edge 0 with Y=0x5A, C=0, then IDLE. Output hold: after done, toggle A/LA/LR with start=0 -> Y/C unchanged.
- Start in SHIFT with new A=0x01 during a 5-bit shift of 0x80 (LR=1, LA=0) -> ignored. Result Y=0x04, C=0. Start asserted during the DONE cycle is also ignored.
- Assert reset asynchronously mid-SHIFT, off a clock edge -> busy, done, Y, C go to 0 immediately. No done pulse follows. A new start after reset release runs normally.
